// File: rtl/fir_filter_mac.sv
// -----------------------------------------------------------------------------
// fir_filter_mac
//
// Signed, time-multiplexed FIR filter: y[n] = sum_k h[k] * x[n-k].
// A single multiplier is shared across all taps. Each accepted sample takes
// TAPS MAC cycles plus one output cycle. The accumulator is rounded
// (round-half-up), shifted right by FRAC and then saturated to OUT_W bits.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_valid      input sample valid (held by the source until o_ready)
//   i_x          signed input sample
//   o_ready      high only in IDLE; a sample is taken when i_valid & o_ready
//   i_clear      synchronous flush of delay line / in-flight computation
//   i_coef_we    coefficient write strobe (honoured only in IDLE)
//   i_coef_addr  tap index k (values >= TAPS are ignored)
//   i_coef_data  signed coefficient h[k]
//   o_valid      one-cycle pulse: o_y / o_sat are new
//   o_y          signed filtered output, held until the next result
//   o_sat        o_y was clipped
// -----------------------------------------------------------------------------
module fir_filter_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int FRAC   = 4,
    parameter int OUT_W  = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_x,
    output logic                     o_ready,
    input  logic                     i_clear,
    input  logic                     i_coef_we,
    input  logic [$clog2(TAPS)-1:0]  i_coef_addr,
    input  logic signed [COEF_W-1:0] i_coef_data,
    output logic                     o_valid,
    output logic signed [OUT_W-1:0]  o_y,
    output logic                     o_sat
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + AW;
    // One extra bit so adding the rounding constant can never wrap.
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] Y_MAX = RND_W'(2**(OUT_W-1) - 1);
    localparam logic signed [RND_W-1:0] Y_MIN = RND_W'(-(2**(OUT_W-1)));
    localparam logic signed [RND_W-1:0] RND_K = RND_W'(2**(FRAC-1));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_reg, state_next;
    logic signed [DATA_W-1:0]  x_reg   [TAPS];
    logic signed [DATA_W-1:0]  x_shift [TAPS];
    logic signed [COEF_W-1:0]  h_reg   [TAPS];
    logic signed [ACC_W-1:0]   acc_reg;
    logic [AW-1:0]             k_reg;
    logic signed [OUT_W-1:0]   y_reg;
    logic                      sat_reg;
    logic                      valid_reg;

    logic                      coef_wr;
    logic signed [PROD_W-1:0]  prod;
    logic signed [RND_W-1:0]   rnd_sum;
    logic signed [RND_W-1:0]   r_val;
    logic signed [OUT_W-1:0]   y_sat;
    logic                      sat_flag;

    assign o_ready = (state_reg == IDLE);
    assign o_valid = valid_reg;
    assign o_y     = y_reg;
    assign o_sat   = sat_reg;

    // Out-of-range addresses (possible when TAPS is not a power of two)
    // must not touch any coefficient.
    assign coef_wr = (state_reg == IDLE) && i_coef_we
                     && (32'(i_coef_addr) < 32'(TAPS));

    // Shifted view of the delay line, loaded when a sample is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign x_shift[gi] = i_x;
            end else begin : g_body
                assign x_shift[gi] = x_reg[gi-1];
            end
        end
    endgenerate

    // Shared multiplier; both operands signed so the product is full precision.
    assign prod = x_reg[k_reg] * h_reg[k_reg];

    // Round half up, then arithmetic shift to drop the fractional bits.
    assign rnd_sum = RND_W'(acc_reg) + RND_K;
    assign r_val   = rnd_sum >>> FRAC;

    always_comb begin
        y_sat    = r_val[OUT_W-1:0];
        sat_flag = 1'b0;
        if (r_val > Y_MAX) begin
            y_sat    = Y_MAX[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (r_val < Y_MIN) begin
            y_sat    = Y_MIN[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides everything and also blocks an accept.
    always_comb begin
        state_next = state_reg;
        if (i_clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (i_valid) state_next = MAC;
                MAC:     if (k_reg == AW'(TAPS - 1)) state_next = OUT;
                OUT:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: delay line, coefficients, accumulator and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_reg[i] <= '0;
                h_reg[i] <= '0;
            end
            acc_reg   <= '0;
            k_reg     <= '0;
            y_reg     <= '0;
            sat_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;

            // Coefficients are independent of clear; a write on the accept
            // edge is seen by the MAC because MAC starts one cycle later.
            if (coef_wr) begin
                h_reg[i_coef_addr] <= i_coef_data;
            end

            if (i_clear) begin
                for (int i = 0; i < TAPS; i++) begin
                    x_reg[i] <= '0;
                end
                acc_reg <= '0;
                k_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (i_valid) begin
                            for (int i = 0; i < TAPS; i++) begin
                                x_reg[i] <= x_shift[i];
                            end
                            acc_reg <= '0;
                            k_reg   <= '0;
                        end
                    end
                    MAC: begin
                        acc_reg <= acc_reg + ACC_W'(prod);
                        k_reg   <= k_reg + 1'b1;
                    end
                    OUT: begin
                        y_reg     <= y_sat;
                        sat_reg   <= sat_flag;
                        valid_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_mac.sv
// -----------------------------------------------------------------------------
// tb_fir_filter_mac
//
// Two instances: dut_a (TAPS=3) for rounding, saturation, clear and reset
// cases; dut_b (TAPS=8) for back-to-back throughput and coefficient-write
// timing. Drivers push hand-computed expectations into per-DUT queues; a
// monitor per DUT pops and compares whenever o_valid is seen, including the
// accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_fir_filter_mac;
    localparam int TA = 3;
    localparam int TB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [11:0] y;
        logic               sat;
        int                 acc_cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    // dut_a signals
    logic              va = 1'b0, ca = 1'b0, wea = 1'b0;
    logic signed [7:0] xa = '0, da = '0;
    logic [1:0]        addra = '0;
    logic              ra, ova, sata;
    logic signed [11:0] ya;

    // dut_b signals
    logic              vb = 1'b0, cb = 1'b0, web = 1'b0;
    logic signed [7:0] xb = '0, db = '0;
    logic [2:0]        addrb = '0;
    logic              rb, ovb, satb;
    logic signed [11:0] yb;

    fir_filter_mac #(.DATA_W(8), .COEF_W(8), .TAPS(TA), .FRAC(4), .OUT_W(12)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .i_x(xa), .o_ready(ra),
        .i_clear(ca), .i_coef_we(wea), .i_coef_addr(addra), .i_coef_data(da),
        .o_valid(ova), .o_y(ya), .o_sat(sata)
    );

    fir_filter_mac #(.DATA_W(8), .COEF_W(8), .TAPS(TB), .FRAC(4), .OUT_W(12)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .i_x(xb), .o_ready(rb),
        .i_clear(cb), .i_coef_we(web), .i_coef_addr(addrb), .i_coef_data(db),
        .o_valid(ovb), .o_y(yb), .o_sat(satb)
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (ova) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_valid: got y=%0d sat=%0d, required no output", ya, sata);
            end else begin
                ea = qa.pop_front();
                if (ya !== ea.y || sata !== ea.sat || (cyc - ea.acc_cyc) != TA + 1) begin
                    errors++;
                    $display("FAIL a_result: got y=%0d sat=%0d lat=%0d, required y=%0d sat=%0d lat=%0d",
                             ya, sata, cyc - ea.acc_cyc, ea.y, ea.sat, TA + 1);
                end else begin
                    $display("a: y=%0d sat=%0d lat=%0d ok", ya, sata, cyc - ea.acc_cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ovb) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_valid: got y=%0d sat=%0d, required no output", yb, satb);
            end else begin
                eb = qb.pop_front();
                if (yb !== eb.y || satb !== eb.sat || (cyc - eb.acc_cyc) != TB + 1) begin
                    errors++;
                    $display("FAIL b_result: got y=%0d sat=%0d lat=%0d, required y=%0d sat=%0d lat=%0d",
                             yb, satb, cyc - eb.acc_cyc, eb.y, eb.sat, TB + 1);
                end else begin
                    $display("b: y=%0d sat=%0d lat=%0d ok", yb, satb, cyc - eb.acc_cyc);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic coef_a(input int a, input int d);
        @(negedge clk);
        wea = 1'b1; addra = 2'(a); da = 8'(d);
        @(negedge clk);
        wea = 1'b0;
    endtask

    task automatic clear_a();
        @(negedge clk);
        ca = 1'b1;
        @(negedge clk);
        ca = 1'b0;
    endtask

    // Presents a sample, waits (bounded) for o_ready, and returns at the
    // negedge after the accepting edge.
    task automatic send_a(input int x, input bit push, input int ey, input bit esat);
        int t;
        @(negedge clk);
        va = 1'b1; xa = 8'(x);
        t = 0;
        while (!ra && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ra) begin
            checks++; errors++;
            $display("FAIL a_accept_timeout: got ready=0, required ready=1");
        end else if (push) begin
            qa.push_back('{12'(ey), esat, cyc + 1});
        end
        @(negedge clk);
        va = 1'b0;
    endtask

    task automatic drain_a();
        int t;
        t = 0;
        while (qa.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("a_drain_pending", qa.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    int xs[4]  = '{3, -5, 7, 2};
    int eys[4] = '{6, -7, 12, 9};
    int accs[4];
    int idx;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_y", ya, 0);
        chk("rst_sat", sata, 0);
        chk("rst_valid", ova, 0);
        chk("rst_ready", ra, 1);
        rst_n = 1'b1;

        // Positive samples, h = {8,5,10}
        coef_a(0, 8); coef_a(1, 5); coef_a(2, 10);
        send_a(4, 1, 2, 0);
        send_a(4, 1, 3, 0);
        send_a(4, 1, 6, 0);
        drain_a();

        // Negative samples after flushing history
        clear_a();
        send_a(-4, 1, -2, 0);
        send_a(-4, 1, -3, 0);
        send_a(-4, 1, -6, 0);
        drain_a();

        // Saturation, all h = 127
        coef_a(0, 127); coef_a(1, 127); coef_a(2, 127);
        clear_a();
        send_a(127, 1, 1008, 0);
        send_a(127, 1, 2016, 0);
        send_a(127, 1, 2047, 1);
        send_a(-128, 1, 1000, 0);
        send_a(-128, 1, -1024, 0);
        send_a(-128, 1, -2048, 1);
        drain_a();

        // Clear mid-MAC: no output, o_y held, history zeroed
        coef_a(0, 8); coef_a(1, 5); coef_a(2, 10);
        coef_a(3, 100);
        send_a(50, 0, 0, 0);
        @(negedge clk);
        ca = 1'b1;
        @(negedge clk);
        ca = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_y_held", ya, -2048);
        chk("clr_sat_held", sata, 1);
        chk("clr_ready", ra, 1);
        send_a(4, 1, 2, 0);
        send_a(4, 1, 3, 0);
        drain_a();

        // dut_b: held i_valid, write on accept edge applied, write in MAC ignored
        for (int k = 0; k < TB; k++) begin
            @(negedge clk);
            web = 1'b1; addrb = 3'(k); db = 8'(16);
        end
        @(negedge clk);
        web = 1'b0;
        @(negedge clk);
        vb = 1'b1; xb = 8'(xs[0]); web = 1'b1; addrb = 3'd0; db = 8'(32);
        idx = 0;
        for (int t = 0; t < 100 && idx < 4; t++) begin
            if (rb) begin
                accs[idx] = cyc + 1;
                qb.push_back('{12'(eys[idx]), 1'b0, cyc + 1});
                idx++;
            end
            @(negedge clk);
            if (t == 0) db = 8'(0);
            if (t == 1) web = 1'b0;
            if (idx < 4) xb = 8'(xs[idx]);
            else vb = 1'b0;
        end
        vb = 1'b0;
        chk("b_accept_count", idx, 4);
        for (int i = 1; i < 4; i++) begin
            if (i < idx) chk("b_accept_spacing", accs[i] - accs[i-1], TB + 2);
        end
        for (int t = 0; t < 40 && qb.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        chk("b_drain_pending", qb.size(), 0);

        // Async reset mid-MAC on dut_a (o_y was 3 before)
        send_a(4, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("amid_rst_y", ya, 0);
        chk("amid_rst_sat", sata, 0);
        chk("amid_rst_valid", ova, 0);
        chk("amid_rst_ready", ra, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send_a(4, 1, 0, 0);
        drain_a();

        repeat (5) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
- Parametrised, signed, time-multiplexed FIR filter: y[n] = sum over k of h[k]*x[n-k], k = 0..TAPS-1.
- Coefficients are run-time programmable; a single multiplier is shared across all taps.
- The output has rounding, a Q-format shift and saturation.
- Generalised successor of the fixed 3-tap unsigned core. It sits between the sample source and the display/output stage, using a valid/ready handshake on input and a valid pulse on output.

Parameters:
- DATA_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width (Q(COEF_W-1-FRAC).FRAC).
- TAPS, 8, number of taps (>=2).
- FRAC, 4, fractional bits removed from the accumulator before output (>=1).
- OUT_W, 12, signed output width after saturation.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  input sample valid.
- i_x  in  DATA_W  signed input sample.
- o_ready  out  1  block can accept a sample (high only in IDLE).
- i_clear  in  1  synchronous flush of the delay line and any in-flight computation.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_addr  in  $clog2(TAPS)  tap index k.
- i_coef_data  in  COEF_W  signed coefficient h[k].
- o_valid  out  1  one-cycle pulse: o_y is new.
- o_y  out  OUT_W  signed filtered output, held until the next result.
- o_sat  out  1  o_y was clipped; updated together with o_y.

Behaviour:
- Reset (async, i_rst_n=0):
  - delay line x[0..TAPS-1]=0, all h[k]=0, accumulator=0.
  - state=IDLE, o_valid=0, o_y=0, o_sat=0, o_ready=1.
- Accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS). Products are full-precision signed, sign-extended to ACC_W. No internal overflow is possible.
- FSM states:
  - IDLE: o_ready=1. On edge with i_valid=1: shift delay line (x[k]<=x[k-1], x[0]<=i_x), acc<=0, k<=0, go MAC.
  - MAC: o_ready=0. Each cycle acc<=acc+x[k]*h[k], k<=k+1. After the edge where k=TAPS-1, go OUT.
  - OUT: r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic, round-half-up).
    - If r > 2^(OUT_W-1)-1: o_y<=max, o_sat<=1.
    - If r < -2^(OUT_W-1): o_y<=min, o_sat<=1.
    - Otherwise o_y<=r[OUT_W-1:0], o_sat<=0.
    - o_valid<=1 for exactly this one cycle. Go IDLE.
- Timing:
  - Sample accepted at edge E0; o_valid/o_y visible after edge E(TAPS+1).
  - o_ready returns high after the same edge; earliest next accept is E(TAPS+2).
  - Maximum throughput is 1 sample per TAPS+2 cycles.
- i_valid while o_ready=0 is not accepted. The source must hold i_valid and i_x until o_ready=1. No sample is dropped silently.
- Coefficient writes:
  - Applied at the edge only when state=IDLE; writes in MAC/OUT are ignored.
  - A write and a sample accept on the same IDLE edge are both performed; the MAC uses the new coefficient.
  - i_coef_addr >= TAPS is ignored.
- i_clear:
  - Any state, highest priority after reset. Zeroes the delay line and accumulator, goes IDLE, suppresses o_valid.
  - o_y/o_sat hold their last value; coefficients are untouched.
  - i_clear with i_valid in IDLE: the clear wins and the sample is not accepted.
- Reset mid-MAC aborts the computation; no o_valid is produced.

Test Plan:
- TAPS=3, FRAC=4, h={8,5,10} (0.5, 0.31, 0.63).
  - Samples 4, 4, 4, each after o_ready -> o_y=2, 3, 6 (52/16=3.25->3, 92/16=5.75->6); o_sat=0.
  - o_valid exactly 4 cycles after each accept.
- Same coefficients, samples -4, -4, -4 -> o_y=-2, -3, -6.
  - -3.25 rounds to -3; -5.75 rounds to -6 via (acc+8)>>>4.
- DATA_W=8, TAPS=3, all h=127:
  - x=127 three times -> third o_y=2047, o_sat=1.
  - Then x=-128 three times -> third o_y=-2048, o_sat=1.
- Hold i_valid=1 continuously with TAPS=8 -> accepts spaced exactly 10 cycles.
  - A coefficient write during MAC is ignored; the result matches the old coefficients.
- Assert i_clear mid-MAC -> no o_valid, o_y unchanged. The next sample 4 with h={8,5,10} gives o_y=2 (history zeroed).
- Assert i_rst_n=0 mid-MAC -> all outputs 0 and o_ready=1 immediately (async); all coefficients read back as 0 (next sample gives o_y=0).
